// File: rtl/register_pkg.sv
// register_pkg: address map, STATUS bit positions and FSM state type shared by register_rd.
package register_pkg;
   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_COUNT  = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;
   localparam int ST_UPDATED = 0;
   localparam int ST_SAT     = 1;
   typedef enum logic {IDLE, RESP} state_e;
endpackage

// File: rtl/register_rd_counter.sv
// register_rd_counter: saturating write-event counter with clear; a same-edge increment beats the clear.
// Ports: clk, rst (async active-low), inc_i (one event per cycle), clr_i (clear),
//        cnt_o (count), sat_o (count is at its maximum).
module register_rd_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o,
   output logic         sat_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign cnt_o = cnt_q;
   assign sat_o = &cnt_q;
   // clear with a coincident event leaves exactly one event counted
   always_comb cnt_d = clr_i ? W'(inc_i) : (inc_i && !sat_o) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
endmodule

// File: rtl/register_rd.sv
// register_rd: Wishbone classic read-back window onto a live register (DATA, COUNT, STATUS).
// Ports: clk, rst (async active-low); reg_data/reg_wren observed register and its write strobe;
//        wb_cyc_i/wb_stb_i/wb_we_i/wb_adr_i/wb_sel_i request; wb_dat_o/wb_ack_o/wb_err_o response.
// Build option: define REGISTER_RD_COUNT_EN to include the COUNT register and STATUS saturation bit.
module register_rd
   import register_pkg::*;
#(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   reg_data,
   input  logic            reg_wren,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic            wb_we_i,
   input  logic [1:0]      wb_adr_i,
   input  logic [DW/8-1:0] wb_sel_i,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   output logic            wb_err_o
);
   state_e            state_q, state_d;
   logic [1:0]        adr_q;
   logic              we_q;
   logic [DW/8-1:0]   sel_q;
   logic [DW-1:0]     snap_q;
   logic              upd_q;
   logic [CNT_W-1:0]  cnt;
   logic              sat;
   logic              accept, resp, bad;
   logic [DW-1:0]     rd, mask, status;

   assign accept = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
   // a master that drops cyc mid-response abandons the cycle: no termination, no side effects
   assign resp   = (state_q == RESP) && wb_cyc_i;

`ifdef REGISTER_RD_COUNT_EN
   assign bad = we_q || (adr_q == ADDR_RSVD);
   register_rd_counter #(.W(CNT_W)) u_counter (
      .clk   (clk),
      .rst   (rst),
      .inc_i (reg_wren),
      .clr_i (wb_ack_o && (adr_q == ADDR_COUNT)),
      .cnt_o (cnt),
      .sat_o (sat)
   );
`else
   assign bad = we_q || (adr_q == ADDR_RSVD) || (adr_q == ADDR_COUNT);
   assign cnt = '0;
   assign sat = 1'b0;
`endif

   assign wb_ack_o = resp && !bad;
   assign wb_err_o = resp && bad;

   always_comb begin
      state_d = (state_q == RESP) ? IDLE : (accept ? RESP : IDLE);
      status = '0;
      status[ST_UPDATED] = upd_q;
      status[ST_SAT] = sat;
      mask = '0;
      for (int i = 0; i < DW/8; i++) mask[8*i +: 8] = {8{sel_q[i]}};
      rd = (adr_q == ADDR_DATA) ? snap_q : (adr_q == ADDR_COUNT) ? DW'(cnt) : (adr_q == ADDR_STATUS) ? status : '0;
      wb_dat_o = wb_ack_o ? (rd & mask) : '0;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= IDLE;
         adr_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         snap_q  <= '0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            adr_q  <= wb_adr_i;
            we_q   <= wb_we_i;
            sel_q  <= wb_sel_i;
            snap_q <= reg_data;
         end
         // a write event outranks the clear from an acked DATA read
         upd_q <= reg_wren || (upd_q && !(wb_ack_o && (adr_q == ADDR_DATA)));
      end
endmodule

// File: tb/tb_register_rd.sv
// tb_register_rd: randomized and directed Wishbone reads of register_rd checked against a behavioural model.
module tb_register_rd;
   localparam int DW = 32, CNT_W = 2, MAXC = (1 << CNT_W) - 1;
`ifdef REGISTER_RD_COUNT_EN
   localparam bit CEN = 1'b1;
`else
   localparam bit CEN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, reg_wren = 1'b0;
   logic wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [DW-1:0] reg_data = '0;
   logic [1:0] wb_adr_i = '0;
   logic [DW/8-1:0] wb_sel_i = '0;
   logic [DW-1:0] wb_dat_o;
   logic wb_ack_o, wb_err_o;
   int n_tests = 0, n_fail = 0, m_cnt = 0;
   bit m_upd = 1'b0;

   always #5 clk = ~clk;

   register_rd #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .reg_data(reg_data), .reg_wren(reg_wren),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o)
   );

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ev();
      m_upd = 1'b1;
      if (m_cnt < MAXC) m_cnt++;
   endtask

   task automatic idle(input int n, input bit rnd);
      repeat (n) begin
         reg_wren = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
         if (reg_wren) ev();
         reg_data = $urandom;
      end
      reg_wren = 1'b0;
   endtask

   task automatic xact(input string tag, input logic [1:0] adr, input bit we, input logic [3:0] sel,
                       input bit w0, input bit w1, input bit drop);
      logic [DW-1:0] snap, v, m;
      bit bad, ack_e;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; reg_wren = w0;
      snap = reg_data;
      step();
      if (w0) ev();
      wb_adr_i = 2'($urandom); wb_we_i = ~we; wb_sel_i = 4'($urandom); reg_data = $urandom;
      wb_cyc_i = !drop; wb_stb_i = !drop; reg_wren = w1;
      bad = we || adr == 2'd3 || (adr == 2'd1 && !CEN);
      ack_e = !drop && !bad;
      v = adr == 2'd0 ? snap : adr == 2'd1 ? DW'(m_cnt) : {30'b0, CEN && m_cnt == MAXC, m_upd};
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
      #1;
      chk({tag, ".ack"}, DW'(wb_ack_o), DW'(ack_e));
      chk({tag, ".err"}, DW'(wb_err_o), DW'(!drop && bad));
      chk({tag, ".dat"}, wb_dat_o, ack_e ? (v & m) : '0);
      step();
      if (ack_e && adr == 2'd0) m_upd = 1'b0;
      if (ack_e && adr == 2'd1) m_cnt = 0;
      if (w1) ev();
      chk({tag, ".gap"}, DW'({wb_ack_o, wb_err_o}), '0);
      chk({tag, ".gapdat"}, wb_dat_o, '0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; reg_wren = 1'b0;
   endtask

   initial begin
      step(); step();
      chk("rst_ack", DW'(wb_ack_o), '0);
      chk("rst_err", DW'(wb_err_o), '0);
      chk("rst_dat", wb_dat_o, '0);
      rst = 1'b1;
      reg_data = 32'h8000_0000;
      xact("data_first", 2'd0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
      xact("status_clr", 2'd2, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
      xact("count_rd1", 2'd1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      xact("count_rd2", 2'd1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      xact("write_err", 2'd0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
      xact("status_upd", 2'd2, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      xact("rsvd_err", 2'd3, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      reg_data = 32'hDEAD_BEEF;
      xact("lane0", 2'd0, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0);
      xact("set_wins", 2'd2, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      idle(5, 1'b0);
      xact("clr_upd", 2'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      xact("sat_status", 2'd2, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      xact("cnt_wren", 2'd1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
      xact("cnt_after", 2'd1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      xact("drop", 2'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1);
      xact("after_drop", 2'd2, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 2'd0; wb_we_i = 1'b0; wb_sel_i = 4'hF;
      step();
      chk("pre_rst_ack", DW'(wb_ack_o), DW'(1));
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_ack", DW'(wb_ack_o), '0);
      chk("mid_rst_err", DW'(wb_err_o), '0);
      chk("mid_rst_dat", wb_dat_o, '0);
      m_cnt = 0; m_upd = 1'b0;
      wb_adr_i = 2'd2;
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("rel_ack", DW'(wb_ack_o), DW'(1));
      chk("rel_dat", wb_dat_o, '0);
      step();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      xact("rel_count", 2'd1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 300; k++) begin
         idle($urandom_range(0, 2), 1'b1);
         reg_data = $urandom;
         xact("rnd", 2'($urandom), $urandom_range(0, 4) == 0, 4'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
